// File: rtl/des_sbox_if.sv
// des_sbox_if -- handshake bundle between a producer of expanded, key-mixed
// DES half-blocks and the S-box substitution engine.
//   in_valid  : producer has a 48-bit half-block on in_data
//   in_ready  : engine can take in_data this cycle
//   in_data   : [47:42] feeds S1 ... [5:0] feeds S8
//   out_valid : out_data holds a completed substitution
//   out_ready : consumer takes out_data this cycle
//   out_data  : S1 nibble in [31:28] ... S8 nibble in [3:0]
// The master modport is the producer/consumer side; slave is the engine side.
interface des_sbox_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_sbox_engine.sv
// des_sbox_engine -- DES S-box substitution layer (S1..S8), evaluating
// LANES S-boxes per clock so one half-block takes 8/LANES RUN cycles.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : des_sbox_if.slave (valid/ready input and output handshakes)
//   busy  : high whenever the FSM is not in IDLE
// A DONE result can be consumed and the next half-block accepted on the same
// edge, giving one result per 8/LANES+1 cycles back to back.
module des_sbox_engine #(
    parameter int LANES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    des_sbox_if.slave      bus,
    output logic           busy
);
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    localparam int GROUPS = 8 / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

    // FIPS 46-3 tables, one 256-bit word per S-box, 64 nibbles row-major
    // (row 0 col 0 in the top nibble).
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [47:0]      din_q, din_d;
    logic [31:0]      res_q, res_d;
    logic [2:0]       sidx;
    logic             in_ready;

    // Row is the outer bit pair, column the middle four bits.
    function automatic logic [3:0] sbox(input logic [2:0] s, input logic [5:0] b);
        logic [5:0] n;
        n = {b[5], b[0], b[4:1]};
        return SBOX[s][4*(63 - int'(n)) +: 4];
    endfunction

    // Zero-based S-box number handled by lane l in group g.
    function automatic logic [2:0] lane_idx(input logic [GRP_W-1:0] g, input int l);
        return 3'(int'(g) * LANES + l);
    endfunction

    assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        din_d   = din_q;
        res_d   = res_q;
        sidx    = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    grp_d   = '0;
                    din_d   = bus.in_data;
                end
            end
            RUN: begin
                // S1 sits in the top chunk/nibble, so offsets count down from 7.
                for (int l = 0; l < LANES; l++) begin
                    sidx = lane_idx(grp_q, l);
                    res_d[4*(7 - int'(sidx)) +: 4] = sbox(sidx, din_q[6*(7 - int'(sidx)) +: 6]);
                end
                if (grp_q == GRP_LAST) begin
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_d = RUN;
                        grp_d   = '0;
                        din_d   = bus.in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            din_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            din_q   <= din_d;
            res_q   <= res_d;
        end
    end
endmodule
